// File: rtl/pmp_scan_checker.sv
// Sequential PMP checker: scans NUM_ENTRIES cfg/addr pairs one per cycle and
// returns allow/hit/entry. Optional TOR matching is built only with PMP_TOR_EN.
module pmp_scan_checker #(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [1:0]       req_size,
  input  logic [1:0]       req_type,
  input  logic             req_mmode,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_allow,
  output logic             resp_hit,
  output logic [IDX_W-1:0] resp_entry,
  input  logic             csr_we,
  input  logic             csr_sel,
  input  logic [IDX_W-1:0] csr_idx,
  input  logic [31:0]      csr_wdata,
  output logic             csr_ready
);

  localparam int unsigned       NE       = NUM_ENTRIES;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_MISS, S_RESP} state_t;

  state_t           state_q, state_d;
  // Stored cfg keeps only meaningful bits: [5]=L [4:3]=A [2]=X [1]=W [0]=R
  logic [5:0]       cfg_q   [NUM_ENTRIES];
  logic [5:0]       cfg_d   [NUM_ENTRIES];
  logic [31:0]      paddr_q [NUM_ENTRIES];
  logic [31:0]      paddr_d [NUM_ENTRIES];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       size_q, size_d;
  logic [1:0]       type_q, type_d;
  logic             mmode_q, mmode_d;
  logic             req_ready_q, req_ready_d;
  logic             csr_ready_q, csr_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_allow_q, resp_allow_d;
  logic             resp_hit_q, resp_hit_d;
  logic [IDX_W-1:0] resp_entry_q, resp_entry_d;

  // Evaluation of the entry currently pointed at by idx_q
  logic [5:0]  cur_cfg;
  logic [31:0] cur_addr;
  logic [5:0]  tz;
  logic        tz_stop;
  logic [31:0] napot_mask;
  logic [34:0] reg_lo, reg_hi, acc_lo, acc_hi;
  logic        reg_on, acc_wrap, match_full, match_part, perm_ok, allow_hit;
`ifdef PMP_TOR_EN
  logic [31:0] prev_addr;
`endif

  always_comb begin
    cur_cfg  = cfg_q[idx_q];
    cur_addr = paddr_q[idx_q];
`ifdef PMP_TOR_EN
    prev_addr = (idx_q == '0) ? '0 : paddr_q[idx_q - 1'b1];
`endif
    tz      = '0;
    tz_stop = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (!tz_stop) begin
        if (cur_addr[i]) tz = 6'(i + 1);
        else             tz_stop = 1'b1;
      end
    end
    napot_mask = 32'((33'd2 << tz) - 33'd1);

    acc_lo   = {3'b000, addr_q};
    acc_hi   = acc_lo + {33'd0, size_q};
    acc_wrap = acc_hi[32];

    reg_on = 1'b0;
    reg_lo = '0;
    reg_hi = '0;
    case (cur_cfg[4:3])
`ifdef PMP_TOR_EN
      2'd1: begin
        reg_lo = {3'b000, prev_addr};
        reg_hi = {3'b000, cur_addr};
        reg_on = (reg_lo < reg_hi);
      end
`endif
      2'd2: begin
        reg_lo = {3'b000, cur_addr[31:2], 2'b00};
        reg_hi = reg_lo + 35'd4;
        reg_on = 1'b1;
      end
      2'd3: begin
        if (&cur_addr) begin
          reg_lo = '0;
          reg_hi = 35'h1_0000_0000;
        end else begin
          reg_lo = {3'b000, cur_addr & ~napot_mask};
          reg_hi = reg_lo + (35'd8 << tz);
        end
        reg_on = 1'b1;
      end
      default: ;
    endcase

    // A wrapping access can never be fully inside, so it counts as partial
    match_full = reg_on && !acc_wrap && (acc_lo >= reg_lo) && (acc_hi < reg_hi);
    match_part = reg_on && !match_full &&
                 (acc_wrap || ((acc_lo < reg_hi) && (acc_hi >= reg_lo)));

    case (type_q)
      2'd0:    perm_ok = cur_cfg[0];
      2'd1:    perm_ok = cur_cfg[1];
      2'd2:    perm_ok = cur_cfg[2];
      default: perm_ok = 1'b0;
    endcase
    allow_hit = match_full && (type_q != 2'd3) && ((mmode_q && !cur_cfg[5]) || perm_ok);
  end

  logic             wr_block;
`ifdef PMP_TOR_EN
  logic [IDX_W-1:0] nxt_idx;
`endif

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    paddr_d      = paddr_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    size_d       = size_q;
    type_d       = type_q;
    mmode_d      = mmode_q;
    resp_valid_d = resp_valid_q;
    resp_allow_d = resp_allow_q;
    resp_hit_d   = resp_hit_q;
    resp_entry_d = resp_entry_q;
    wr_block     = 1'b0;
`ifdef PMP_TOR_EN
    nxt_idx      = csr_idx + 1'b1;
`endif

    case (state_q)
      S_IDLE: begin
        if (csr_we && (32'(csr_idx) < NE)) begin
          wr_block = cfg_q[csr_idx][5];
`ifdef PMP_TOR_EN
          if (csr_sel && ((32'(csr_idx) + 32'd1) < NE) &&
              cfg_q[nxt_idx][5] && (cfg_q[nxt_idx][4:3] == 2'd1))
            wr_block = 1'b1;
`endif
          if (!wr_block) begin
            if (csr_sel) paddr_d[csr_idx] = csr_wdata;
            else         cfg_d[csr_idx]   = {csr_wdata[7], csr_wdata[4:0]};
          end
        end
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = (req_size == 2'd2) ? 2'd3 : req_size;
          type_d  = req_type;
          mmode_d = req_mmode;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (match_full || match_part) begin
          resp_hit_d   = 1'b1;
          resp_allow_d = allow_hit;
          resp_entry_d = idx_q;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_MISS;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      // Extra step after the last miss so a no-hit answer takes NUM_ENTRIES+1 cycles
      S_MISS: begin
        resp_hit_d   = 1'b0;
        resp_allow_d = mmode_q && (type_q != 2'd3);
        resp_entry_d = '0;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_allow_d = 1'b0;
          resp_hit_d   = 1'b0;
          resp_entry_d = '0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    csr_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      for (int unsigned i = 0; i < NE; i++) begin
        cfg_q[i]   <= '0;
        paddr_q[i] <= '0;
      end
      idx_q        <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      type_q       <= '0;
      mmode_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      csr_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_allow_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_entry_q <= '0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      paddr_q      <= paddr_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      type_q       <= type_d;
      mmode_q      <= mmode_d;
      req_ready_q  <= req_ready_d;
      csr_ready_q  <= csr_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_allow_q <= resp_allow_d;
      resp_hit_q   <= resp_hit_d;
      resp_entry_q <= resp_entry_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign csr_ready  = csr_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_allow = resp_allow_q;
  assign resp_hit   = resp_hit_q;
  assign resp_entry = resp_entry_q;

endmodule

// File: tb/tb_pmp_scan_checker.sv
// Directed bench for pmp_scan_checker (4 entries); TOR expectations follow PMP_TOR_EN.
module tb_pmp_scan_checker;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [31:0]   req_addr;
  logic [1:0]    req_size, req_type;
  logic          req_mmode;
  logic          resp_valid, resp_ready, resp_allow, resp_hit;
  logic [IW-1:0] resp_entry;
  logic          csr_we, csr_sel, csr_ready;
  logic [IW-1:0] csr_idx;
  logic [31:0]   csr_wdata;

  always #5 clk = ~clk;

  pmp_scan_checker #(.NUM_ENTRIES(N), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_type(req_type), .req_mmode(req_mmode),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_allow(resp_allow),
    .resp_hit(resp_hit), .resp_entry(resp_entry),
    .csr_we(csr_we), .csr_sel(csr_sel), .csr_idx(csr_idx),
    .csr_wdata(csr_wdata), .csr_ready(csr_ready)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  logic          r_hit, r_allow, r_stable, r_rdy;
  logic [IW-1:0] r_entry;
  int            r_lat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic csr_wr(input logic sel, input logic [IW-1:0] idx, input logic [31:0] data);
    @(negedge clk);
    csr_we = 1'b1; csr_sel = sel; csr_idx = idx; csr_wdata = data;
    @(posedge clk); #1;
    csr_we = 1'b0;
  endtask

  // Issue one request (optionally with a same-cycle cfg write), wait for the
  // response, optionally stall it, then complete the handshake.
  task automatic access_full(input logic [31:0] addr, input logic [1:0] size,
                             input logic [1:0] typ, input logic mm, input int hold,
                             input logic we, input logic [IW-1:0] cidx,
                             input logic [31:0] cdata);
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_size = size; req_type = typ; req_mmode = mm;
    csr_we = we; csr_sel = 1'b0; csr_idx = cidx; csr_wdata = cdata;
    @(posedge clk); #1;
    req_valid = 1'b0; csr_we = 1'b0;
    r_lat = 0;
    while (!resp_valid && r_lat < 50) begin
      @(posedge clk); #1;
      r_lat++;
    end
    r_hit = resp_hit; r_allow = resp_allow; r_entry = resp_entry;
    r_stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_hit !== r_hit || resp_allow !== r_allow ||
          resp_entry !== r_entry) r_stable = 1'b0;
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    r_rdy = req_ready;
  endtask

  task automatic access(input logic [31:0] addr, input logic [1:0] size,
                        input logic [1:0] typ, input logic mm);
    access_full(addr, size, typ, mm, 0, 1'b0, '0, '0);
  endtask

  task automatic expect_resp(input string tag, input logic hit, input logic allow,
                             input logic [IW-1:0] entry, input int lat);
    check_eq({tag, "_hit"},   32'(r_hit),   32'(hit));
    check_eq({tag, "_allow"}, 32'(r_allow), 32'(allow));
    check_eq({tag, "_entry"}, 32'(r_entry), 32'(entry));
    check_eq({tag, "_lat"},   32'(r_lat),   32'(lat));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0; req_type = '0;
    req_mmode = 1'b0; resp_ready = 1'b0; csr_we = 1'b0; csr_sel = 1'b0;
    csr_idx = '0; csr_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_ready",  32'(req_ready),  32'd1);
    check_eq("rst_csr_ready",  32'(csr_ready),  32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_allow", 32'(resp_allow), 32'd0);
    check_eq("rst_resp_hit",   32'(resp_hit),   32'd0);
    check_eq("rst_resp_entry", 32'(resp_entry), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // All entries OFF, U-mode read misses after N+1 cycles
    access(32'h1000, 2'd0, 2'd0, 1'b0);
    expect_resp("off_read", 1'b0, 1'b0, 2'd0, 5);
    check_eq("b2b_ready", 32'(r_rdy), 32'd1);

    // Entry 2 NAPOT 32 B at 0x1000, R only
    csr_wr(1'b1, 2'd2, 32'h0000_1003);
    csr_wr(1'b0, 2'd2, 32'h19);
    access_full(32'h101C, 2'd3, 2'd0, 1'b0, 3, 1'b0, '0, '0);
    expect_resp("napot_read", 1'b1, 1'b1, 2'd2, 3);
    check_eq("hold_stable", 32'(r_stable), 32'd1);
    access(32'h101C, 2'd3, 2'd1, 1'b0);
    expect_resp("napot_write", 1'b1, 1'b0, 2'd2, 3);
    access(32'h101E, 2'd3, 2'd0, 1'b0);
    expect_resp("napot_cross", 1'b1, 1'b0, 2'd2, 3);
    access(32'h101D, 2'd2, 2'd0, 1'b0);
    expect_resp("size2_as_word", 1'b1, 1'b0, 2'd2, 3);
    access(32'h1000, 2'd0, 2'd1, 1'b1);
    expect_resp("m_unlocked", 1'b1, 1'b1, 2'd2, 3);
    access(32'h1000, 2'd0, 2'd3, 1'b1);
    expect_resp("m_reserved", 1'b1, 1'b0, 2'd2, 3);

    // cfg write in the accept cycle is seen by the scan
    access_full(32'h1000, 2'd0, 2'd1, 1'b0, 0, 1'b1, 2'd2, 32'h1B);
    expect_resp("same_cycle_wr", 1'b1, 1'b1, 2'd2, 3);

    // Entry 0 NA4 0x2000 no perms, entry 1 NAPOT 64 B at 0x2000 RWX
    csr_wr(1'b1, 2'd0, 32'h0000_2000);
    csr_wr(1'b0, 2'd0, 32'h10);
    csr_wr(1'b1, 2'd1, 32'h0000_2007);
    csr_wr(1'b0, 2'd1, 32'h1F);
    access(32'h2000, 2'd3, 2'd0, 1'b1);
    expect_resp("na4_m_read", 1'b1, 1'b1, 2'd0, 1);
    csr_wr(1'b0, 2'd0, 32'h90);
    access(32'h2000, 2'd3, 2'd0, 1'b1);
    expect_resp("na4_locked", 1'b1, 1'b0, 2'd0, 1);
    csr_wr(1'b0, 2'd0, 32'h1F);
    csr_wr(1'b1, 2'd0, 32'h0000_5000);
    access(32'h2000, 2'd3, 2'd0, 1'b1);
    expect_resp("lock_ignores_wr", 1'b1, 1'b0, 2'd0, 1);
    access(32'h2004, 2'd3, 2'd0, 1'b0);
    expect_resp("entry1_read", 1'b1, 1'b1, 2'd1, 2);
    access(32'hFFFF_FFFE, 2'd3, 2'd0, 1'b0);
    expect_resp("wrap_partial", 1'b1, 1'b0, 2'd0, 1);
    access(32'h8000, 2'd0, 2'd0, 1'b1);
    expect_resp("m_miss", 1'b0, 1'b1, 2'd0, 5);

    // TOR region [0x3000, 0x4000) on entry 3, X only
    csr_wr(1'b0, 2'd2, 32'h00);
    csr_wr(1'b1, 2'd2, 32'h0000_3000);
    csr_wr(1'b1, 2'd3, 32'h0000_4000);
    csr_wr(1'b0, 2'd3, 32'h0C);
    access(32'h3FFC, 2'd3, 2'd2, 1'b0);
`ifdef PMP_TOR_EN
    expect_resp("tor_exec", 1'b1, 1'b1, 2'd3, 4);
`else
    expect_resp("tor_exec", 1'b0, 1'b0, 2'd0, 5);
`endif
    access(32'h4000, 2'd0, 2'd2, 1'b0);
    expect_resp("tor_above", 1'b0, 1'b0, 2'd0, 5);
    csr_wr(1'b0, 2'd3, 32'h8C);
    csr_wr(1'b1, 2'd2, 32'h0000_3F00);
    access(32'h3004, 2'd0, 2'd2, 1'b0);
`ifdef PMP_TOR_EN
    expect_resp("tor_lock_base", 1'b1, 1'b1, 2'd3, 4);
`else
    expect_resp("tor_lock_base", 1'b0, 1'b0, 2'd0, 5);
`endif

    // Reset while scanning drops the request and clears locked entries
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h9000; req_size = 2'd0; req_type = 2'd0; req_mmode = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("scan_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(resp_valid), 32'd0);
    check_eq("midrst_ready", 32'(req_ready),  32'd1);
    @(posedge clk); #1;
    check_eq("midrst_valid_edge", 32'(resp_valid), 32'd0);
    check_eq("midrst_ready_edge", 32'(req_ready),  32'd1);
    @(negedge clk); rst_n = 1'b1;
    access(32'h2000, 2'd3, 2'd0, 1'b1);
    expect_resp("post_rst_m_read", 1'b0, 1'b1, 2'd0, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
